// File: rtl/cache_wb_if.sv
`default_nettype none
// ============================================================================
//  Module   : cache_wb_if
//  Purpose  : Bundles the CPU request/response signals and the word-wide
//             memory handshake of the write-back cache into one interface.
//  Modports : slave  - the cache (takes requests, drives memory requests)
//             master - the environment (CPU pipeline plus main memory)
//  Signals  : stall, input_ready, addr, write_data, w_en, be   (CPU -> cache)
//             hit, read_data                                   (cache -> CPU)
//             maddr, mwrite_data, m_wen, m_ren                 (cache -> mem)
//             mread_data, mready                               (mem -> cache)
//  Revision : 1.0 - initial release
// ============================================================================
interface cache_wb_if;
   logic        stall;
   logic        input_ready;
   logic [31:0] addr;
   logic [31:0] write_data;
   logic        w_en;
   logic [3:0]  be;
   logic        hit;
   logic [31:0] read_data;
   logic [31:0] maddr;
   logic [31:0] mwrite_data;
   logic        m_wen;
   logic        m_ren;
   logic [31:0] mread_data;
   logic        mready;

   modport slave (
      input  stall, input_ready, addr, write_data, w_en, be, mread_data, mready,
      output hit, read_data, maddr, mwrite_data, m_wen, m_ren
   );

   modport master (
      output stall, input_ready, addr, write_data, w_en, be, mread_data, mready,
      input  hit, read_data, maddr, mwrite_data, m_wen, m_ren
   );
endinterface
`default_nettype wire

// File: rtl/cache_wb.sv
`default_nettype none
// ============================================================================
//  Module   : cache_wb
//  Purpose  : N-way set-associative write-back, write-allocate cache with
//             multi-word lines, per-line dirty bits, true-LRU replacement,
//             byte-enable stores and a word-at-a-time memory handshake.
//  Ports    : clk   - clock, all state on the rising edge
//             reset - synchronous, active-high
//             bus   - cache_wb_if.slave (CPU request/response + memory bus)
//  Revision : 1.0 - initial release
// ============================================================================
module cache_wb #(
   parameter int TAG_WIDTH    = 24,
   parameter int SET_WIDTH    = 4,
   parameter int OFFSET_WIDTH = 4,
   parameter int LINES        = 2
) (
   input  wire logic   clk,
   input  wire logic   reset,
   cache_wb_if.slave   bus
);

   localparam int SETS  = 2 ** SET_WIDTH;
   localparam int WORDS = 2 ** (OFFSET_WIDTH - 2);
   localparam int KW    = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam int WAYW  = (LINES > 1) ? $clog2(LINES) : 1;
   localparam logic [KW-1:0] K_LAST = KW'(WORDS - 1);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WRITEBACK = 2'd1,
      REFILL    = 2'd2
   } state_t;

   state_t                 state_q;
   logic [KW-1:0]          k_q;
   logic [SET_WIDTH-1:0]   set_q;
   logic [TAG_WIDTH-1:0]   tag_q;
   logic [WAYW-1:0]        vic_q;
   logic                   m_wen_q;
   logic                   m_ren_q;
   logic [31:0]            maddr_q;
   logic [31:0]            mwdata_q;

   logic [TAG_WIDTH-1:0]   tags_q  [SETS][LINES];
   logic [LINES-1:0]       valid_q [SETS];
   logic [LINES-1:0]       dirty_q [SETS];
   logic [31:0]            data_q  [SETS][LINES][WORDS];

   // ---------------------------------------------------------------- decode
   logic [TAG_WIDTH-1:0]   w_tag;
   logic [SET_WIDTH-1:0]   w_set;
   logic [KW-1:0]          w_word;

   assign w_tag  = bus.addr[31 -: TAG_WIDTH];
   assign w_set  = bus.addr[OFFSET_WIDTH +: SET_WIDTH];
   assign w_word = KW'((bus.addr >> 2) & 32'(WORDS - 1));

   function automatic logic [31:0] line_addr(input logic [TAG_WIDTH-1:0] t,
                                             input logic [SET_WIDTH-1:0] s,
                                             input logic [KW-1:0]        k);
      logic [31:0] a;
      a = {t, s, {OFFSET_WIDTH{1'b0}}};
      a = a | (32'(k) << 2);
      return a;
   endfunction

   // ---------------------------------------------------------------- lookup
   logic                   w_hit_any;
   logic [WAYW-1:0]        w_hit_way;

   always_comb begin
      w_hit_any = 1'b0;
      w_hit_way = '0;
      // Descending scan so the lowest matching way wins.
      for (int i = LINES - 1; i >= 0; i--) begin
         if (valid_q[w_set][i] && (tags_q[w_set][i] == w_tag)) begin
            w_hit_any = 1'b1;
            w_hit_way = WAYW'(i);
         end
      end
   end

   logic w_idle_req;
   logic w_commit;
   logic w_miss_start;
   logic w_refill_beat;
   logic w_fill_done;
   logic [WAYW-1:0] w_vic;

   assign w_idle_req    = (state_q == IDLE) && bus.input_ready;
   assign w_commit      = w_idle_req && !bus.stall && w_hit_any;
   assign w_miss_start  = w_idle_req && !bus.stall && !w_hit_any;
   assign w_refill_beat = (state_q == REFILL) && bus.mready;
   assign w_fill_done   = w_refill_beat && (k_q == K_LAST);

   assign bus.hit         = w_idle_req && w_hit_any;
   assign bus.read_data   = bus.hit ? data_q[w_set][w_hit_way][w_word] : 32'd0;
   assign bus.m_wen       = m_wen_q;
   assign bus.m_ren       = m_ren_q;
   assign bus.maddr       = maddr_q;
   assign bus.mwrite_data = mwdata_q;

   // ------------------------------------------------------------------- LRU
   generate
      if (LINES > 1) begin : g_lru
         // Age 0 = most recently used; ages in a set are a permutation.
         logic [WAYW-1:0]      age_q [SETS][LINES];
         logic                 w_acc;
         logic [WAYW-1:0]      w_acc_way;
         logic [SET_WIDTH-1:0] w_acc_set;

         always_comb begin
            w_vic = '0;
            for (int i = LINES - 1; i >= 0; i--) begin
               if (age_q[w_set][i] == WAYW'(LINES - 1)) w_vic = WAYW'(i);
            end
            // Any invalid way overrides the oldest one, lowest index first.
            for (int i = LINES - 1; i >= 0; i--) begin
               if (!valid_q[w_set][i]) w_vic = WAYW'(i);
            end
         end

         // Completing a refill counts as touching the victim way.
         assign w_acc     = w_commit || w_fill_done;
         assign w_acc_way = w_fill_done ? vic_q : w_hit_way;
         assign w_acc_set = w_fill_done ? set_q : w_set;

         always_ff @(posedge clk) begin
            if (reset) begin
               for (int s = 0; s < SETS; s++) begin
                  for (int i = 0; i < LINES; i++) begin
                     age_q[s][i] <= WAYW'(i);
                  end
               end
            end else if (w_acc) begin
               for (int i = 0; i < LINES; i++) begin
                  if (age_q[w_acc_set][i] < age_q[w_acc_set][w_acc_way]) begin
                     age_q[w_acc_set][i] <= age_q[w_acc_set][i] + 1'b1;
                  end
               end
               age_q[w_acc_set][w_acc_way] <= '0;
            end
         end
      end else begin : g_no_lru
         assign w_vic = '0;
      end
   endgenerate

   // ------------------------------------------------------------ data array
   // Not reset: validity is tracked separately, so stale words are harmless.
   always_ff @(posedge clk) begin
      if (w_refill_beat) begin
         data_q[set_q][vic_q][k_q] <= bus.mread_data;
      end else if (w_commit && bus.w_en) begin
         for (int i = 0; i < 4; i++) begin
            if (bus.be[i]) begin
               data_q[w_set][w_hit_way][w_word][8*i +: 8] <= bus.write_data[8*i +: 8];
            end
         end
      end
   end

   // ------------------------------------------------------------------- FSM
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         k_q      <= '0;
         set_q    <= '0;
         tag_q    <= '0;
         vic_q    <= '0;
         m_wen_q  <= 1'b0;
         m_ren_q  <= 1'b0;
         maddr_q  <= '0;
         mwdata_q <= '0;
         for (int s = 0; s < SETS; s++) begin
            valid_q[s] <= '0;
            dirty_q[s] <= '0;
         end
      end else begin
         case (state_q)
            IDLE: begin
               if (w_commit && bus.w_en) begin
                  dirty_q[w_set][w_hit_way] <= 1'b1;
               end else if (w_miss_start) begin
                  set_q <= w_set;
                  tag_q <= w_tag;
                  vic_q <= w_vic;
                  k_q   <= '0;
                  if (valid_q[w_set][w_vic] && dirty_q[w_set][w_vic]) begin
                     state_q  <= WRITEBACK;
                     m_wen_q  <= 1'b1;
                     maddr_q  <= line_addr(tags_q[w_set][w_vic], w_set, '0);
                     mwdata_q <= data_q[w_set][w_vic][0];
                  end else begin
                     state_q  <= REFILL;
                     m_ren_q  <= 1'b1;
                     maddr_q  <= line_addr(w_tag, w_set, '0);
                  end
               end
            end

            WRITEBACK: begin
               if (bus.mready) begin
                  if (k_q == K_LAST) begin
                     k_q      <= '0;
                     state_q  <= REFILL;
                     m_wen_q  <= 1'b0;
                     m_ren_q  <= 1'b1;
                     mwdata_q <= '0;
                     maddr_q  <= line_addr(tag_q, set_q, '0);
                  end else begin
                     k_q      <= k_q + 1'b1;
                     maddr_q  <= line_addr(tags_q[set_q][vic_q], set_q, k_q + 1'b1);
                     mwdata_q <= data_q[set_q][vic_q][k_q + 1'b1];
                  end
               end
            end

            REFILL: begin
               if (bus.mready) begin
                  if (k_q == K_LAST) begin
                     k_q                   <= '0;
                     state_q               <= IDLE;
                     m_ren_q               <= 1'b0;
                     maddr_q               <= '0;
                     tags_q[set_q][vic_q]  <= tag_q;
                     valid_q[set_q][vic_q] <= 1'b1;
                     dirty_q[set_q][vic_q] <= 1'b0;
                  end else begin
                     k_q     <= k_q + 1'b1;
                     maddr_q <= line_addr(tag_q, set_q, k_q + 1'b1);
                  end
               end
            end

            default: begin
               state_q <= IDLE;
               m_wen_q <= 1'b0;
               m_ren_q <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_cache_wb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cache_wb
//  Purpose  : Self-checking bench for cache_wb. Keeps a line-level model of
//             the cache (timestamp LRU) and a sparse word memory, drives
//             directed scenarios followed by randomized traffic.
//  Ports    : none (top level)
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cache_wb;
   localparam int T = 24, S = 4, B = 4, L = 2;
   localparam int SETS = 16, WORDS = 4;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   cache_wb_if bus();

   cache_wb #(.TAG_WIDTH(T), .SET_WIDTH(S), .OFFSET_WIDTH(B), .LINES(L)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int vectors = 0;
   int miscompares = 0;

   // --------------------------------------------------------- memory model
   logic [31:0] mem [logic [31:0]];

   function automatic logic [31:0] mem_rd(input logic [31:0] a);
      if (mem.exists(a)) return mem[a];
      return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
   endfunction

   // ---------------------------------------------------------- cache model
   bit           m_valid [SETS][L];
   bit           m_dirty [SETS][L];
   logic [T-1:0] m_tag   [SETS][L];
   logic [31:0]  m_data  [SETS][L][WORDS];
   longint       m_last  [SETS][L];
   longint       stamp;

   typedef struct {
      bit          wen;
      logic [31:0] a;
      logic [31:0] d;
   } beat_t;

   logic [31:0] log_addr [$];
   bit          log_wen  [$];
   logic [31:0] log_data [$];
   int          fill_cycles;
   int          mr_mode;
   bit          mr_tog;

   task automatic clear_logs();
      log_addr.delete();
      log_wen.delete();
      log_data.delete();
      fill_cycles = 0;
   endtask

   task automatic model_reset();
      stamp = 0;
      for (int s = 0; s < SETS; s++)
         for (int w = 0; w < L; w++) begin
            m_valid[s][w] = 0;
            m_dirty[s][w] = 0;
            m_last[s][w]  = -longint'(w);   // way 0 starts as most recent
         end
   endtask

   function automatic int lookup(input logic [T-1:0] tg, input int st);
      for (int w = 0; w < L; w++)
         if (m_valid[st][w] && m_tag[st][w] == tg) return w;
      return -1;
   endfunction

   function automatic int victim(input int st);
      int v = 0;
      for (int w = 0; w < L; w++) if (!m_valid[st][w]) return w;
      for (int w = 1; w < L; w++) if (m_last[st][w] < m_last[st][v]) v = w;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic pick_mready(output logic r);
      case (mr_mode)
         0: r = 1'b1;
         1: begin mr_tog = ~mr_tog; r = mr_tog; end
         default: r = 1'($urandom_range(1));
      endcase
   endtask

   // Runs the memory transfer that follows a committed miss, checking each
   // cycle's bus against the expected beat list, then installs the line.
   task automatic do_fill(input logic [T-1:0] tg, input int st);
      beat_t q[$];
      beat_t b;
      int    v;
      int    budget;
      logic  r;
      v = victim(st);
      if (m_valid[st][v] && m_dirty[st][v])
         for (int k = 0; k < WORDS; k++) begin
            b.wen = 1; b.a = {m_tag[st][v], 4'(st), 2'(k), 2'b00}; b.d = m_data[st][v][k];
            q.push_back(b);
         end
      for (int k = 0; k < WORDS; k++) begin
         b.wen = 0; b.a = {tg, 4'(st), 2'(k), 2'b00}; b.d = '0;
         q.push_back(b);
      end
      budget = 200;
      while (q.size() > 0 && budget > 0) begin
         @(negedge clk);
         budget--;
         fill_cycles++;
         bus.stall = 1'($urandom_range(1));
         pick_mready(r);
         bus.mready = r;
         bus.mread_data = (r && !q[0].wen) ? mem_rd(q[0].a) : $urandom;
         #1;
         chk("busy_hit", 32'(bus.hit), 32'd0);
         chk("m_wen", 32'(bus.m_wen), 32'(q[0].wen));
         chk("m_ren", 32'(bus.m_ren), 32'(!q[0].wen));
         chk("maddr", bus.maddr, q[0].a);
         if (q[0].wen) chk("mwrite_data", bus.mwrite_data, q[0].d);
         if (r) begin
            if (q[0].wen) mem[q[0].a] = q[0].d;
            log_addr.push_back(q[0].a);
            log_wen.push_back(q[0].wen);
            log_data.push_back(q[0].d);
            void'(q.pop_front());
         end
      end
      if (q.size() > 0) chk("fill_timeout", 32'(q.size()), 32'd0);
      m_valid[st][v] = 1;
      m_dirty[st][v] = 0;
      m_tag[st][v]   = tg;
      for (int k = 0; k < WORDS; k++) m_data[st][v][k] = mem_rd({tg, 4'(st), 2'(k), 2'b00});
      m_last[st][v] = ++stamp;
   endtask

   // One CPU request held until it hits and commits with stall low.
   task automatic access(input logic [31:0] a, input logic we, input logic [31:0] wd,
                         input logic [3:0] bev, input int stall_pct, input bit force_stall,
                         output logic [31:0] rd);
      logic [T-1:0] tg;
      int st, wi, way, guard;
      bit done;
      tg = a[31:8]; st = int'(a[7:4]); wi = int'(a[3:2]);
      done = 0; guard = 0; rd = '0;
      while (!done && guard < 40) begin
         @(negedge clk);
         guard++;
         bus.input_ready = 1; bus.addr = a; bus.w_en = we; bus.write_data = wd; bus.be = bev;
         bus.stall  = (force_stall && guard == 1) ? 1'b1 : ($urandom_range(99) < stall_pct);
         bus.mready = 1'($urandom_range(1));
         #1;
         way = lookup(tg, st);
         chk("idle_m_wen", 32'(bus.m_wen), 32'd0);
         chk("idle_m_ren", 32'(bus.m_ren), 32'd0);
         if (way >= 0) begin
            chk("hit", 32'(bus.hit), 32'd1);
            chk("read_data", bus.read_data, m_data[st][way][wi]);
            rd = bus.read_data;
            if (!bus.stall) begin
               if (we) begin
                  for (int i = 0; i < 4; i++)
                     if (bev[i]) m_data[st][way][wi][8*i +: 8] = wd[8*i +: 8];
                  m_dirty[st][way] = 1;
               end
               m_last[st][way] = ++stamp;
               done = 1;
            end
         end else begin
            chk("miss_hit", 32'(bus.hit), 32'd0);
            chk("miss_rdata", bus.read_data, 32'd0);
            if (!bus.stall) do_fill(tg, st);
         end
      end
      if (!done) chk("access_timeout", 32'(guard), 32'd0);
   endtask

   task automatic idle_cycle();
      @(negedge clk);
      bus.input_ready = 0; bus.addr = $urandom; bus.stall = 1'($urandom_range(1));
      #1;
      chk("idle_hit", 32'(bus.hit), 32'd0);
      chk("idle_rdata", bus.read_data, 32'd0);
      chk("idle_wen", 32'(bus.m_wen), 32'd0);
      chk("idle_ren", 32'(bus.m_ren), 32'd0);
   endtask

   task automatic reset_dut();
      @(negedge clk);
      reset = 1; bus.input_ready = 0; bus.stall = 0; bus.mready = 0;
      @(negedge clk);
      reset = 0;
      model_reset();
      #1;
      chk("rst_hit", 32'(bus.hit), 32'd0);
      chk("rst_rdata", bus.read_data, 32'd0);
      chk("rst_m_wen", 32'(bus.m_wen), 32'd0);
      chk("rst_m_ren", 32'(bus.m_ren), 32'd0);
      chk("rst_maddr", bus.maddr, 32'd0);
      chk("rst_mwdata", bus.mwrite_data, 32'd0);
   endtask

   function automatic int count_wr();
      int n = 0;
      foreach (log_wen[i]) if (log_wen[i]) n++;
      return n;
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, vectors %0d", vectors);
      $fatal(1);
   end

   initial begin
      logic [31:0] rd;
      reset = 1;
      bus.stall = 0; bus.input_ready = 0; bus.addr = 0; bus.write_data = 0;
      bus.w_en = 0; bus.be = 0; bus.mread_data = 0; bus.mready = 0;
      mr_mode = 0; mr_tog = 0;
      model_reset();
      reset_dut();

      // Cold load with mready tied high.
      mem[32'h100] = 32'hA0A0_0100;
      mem[32'h104] = 32'h1234_5678;
      clear_logs(); mr_mode = 0;
      access(32'h100, 0, 0, 4'h0, 0, 0, rd);
      chk("t1_rd", rd, 32'hA0A0_0100);
      chk("t1_beats", 32'(log_addr.size()), 32'd4);
      chk("t1_addr0", log_addr[0], 32'h100);
      chk("t1_addr3", log_addr[3], 32'h10C);
      chk("t1_writes", 32'(count_wr()), 32'd0);
      chk("t1_cycles", 32'(fill_cycles), 32'd4);

      // Partial store hit, then readback; no memory traffic.
      clear_logs();
      access(32'h104, 1, 32'hDEAD_BEEF, 4'b0011, 0, 0, rd);
      access(32'h104, 0, 0, 4'h0, 0, 0, rd);
      chk("t2_merge", rd, 32'h1234_BEEF);
      // Store first presented with stall high, then committed.
      access(32'h104, 1, 32'h5566_7788, 4'b1100, 0, 1, rd);
      access(32'h104, 0, 0, 4'h0, 0, 0, rd);
      chk("t5_merge", rd, 32'h5566_BEEF);
      chk("t2_no_traffic", 32'(log_addr.size()), 32'd0);

      // Miss with stall high must not start a transfer.
      @(negedge clk);
      bus.input_ready = 1; bus.addr = 32'h300; bus.w_en = 0; bus.stall = 1;
      #1 chk("smiss_hit", 32'(bus.hit), 32'd0);
      idle_cycle();

      // Dirty eviction of the LRU line.
      reset_dut();
      access(32'h0100, 0, 0, 4'h0, 0, 0, rd);
      access(32'h1100, 1, 32'hCAFE_F00D, 4'hF, 0, 0, rd);
      access(32'h2100, 0, 0, 4'h0, 0, 0, rd);
      clear_logs();
      access(32'h0100, 0, 0, 4'h0, 0, 0, rd);
      chk("t3_beats", 32'(log_addr.size()), 32'd8);
      chk("t3_writes", 32'(count_wr()), 32'd4);
      chk("t3_wb_addr0", log_addr[0], 32'h1100);
      chk("t3_wb_data0", log_data[0], 32'hCAFE_F00D);
      chk("t3_wb_addr3", log_addr[3], 32'h110C);
      chk("t3_rf_addr0", log_addr[4], 32'h0100);

      // mready toggling during refill.
      clear_logs(); mr_mode = 1; mr_tog = 0;
      access(32'h0200, 0, 0, 4'h0, 0, 0, rd);
      chk("t4_cycles", 32'(fill_cycles), 32'd7);
      chk("t4_beats", 32'(log_addr.size()), 32'd4);

      // Reset during the third write-back beat.
      reset_dut(); mr_mode = 0;
      access(32'h0110, 1, 32'h1111_1111, 4'hF, 0, 0, rd);
      access(32'h1110, 1, 32'h2222_2222, 4'hF, 0, 0, rd);
      @(negedge clk);
      bus.input_ready = 1; bus.addr = 32'h2110; bus.w_en = 0; bus.stall = 0; bus.mready = 1;
      #1 chk("t6_miss", 32'(bus.hit), 32'd0);
      @(negedge clk);
      #1 chk("t6_wen0", 32'(bus.m_wen), 32'd1);
      chk("t6_addr0", bus.maddr, 32'h110);
      chk("t6_data0", bus.mwrite_data, 32'h1111_1111);
      mem[32'h110] = 32'h1111_1111;
      @(negedge clk);
      #1 chk("t6_addr1", bus.maddr, 32'h114);
      @(negedge clk);
      reset = 1; bus.mready = 0;
      #1 chk("t6_addr2", bus.maddr, 32'h118);
      chk("t6_wen2", 32'(bus.m_wen), 32'd1);
      @(negedge clk);
      reset = 0; bus.input_ready = 0;
      model_reset();
      #1 chk("t6_wen_drop", 32'(bus.m_wen), 32'd0);
      chk("t6_ren_drop", 32'(bus.m_ren), 32'd0);
      clear_logs();
      access(32'h0110, 0, 0, 4'h0, 0, 0, rd);
      chk("t6_reload_beats", 32'(log_addr.size()), 32'd4);
      chk("t6_reload_rd", rd, 32'h1111_1111);

      // Randomized traffic over a few sets and tags to force evictions.
      reset_dut(); mr_mode = 2;
      for (int n = 0; n < 300; n++) begin
         if ($urandom_range(7) == 0) idle_cycle();
         else access({24'($urandom_range(4)), 4'($urandom_range(3)), 2'($urandom_range(3)), 2'b00},
                     1'($urandom_range(1)), $urandom, 4'($urandom_range(15)), 20, 0, rd);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/cache_wb.md
Name: cache_wb

Overview:
- Parametrised N-way set-associative write-back, write-allocate cache between the CPU pipeline and word-wide main memory.
- Successor to the single-port write-through cache wrapper. Adds the following:
  - multi-word lines;
  - per-line dirty bits with victim write-back;
  - true-LRU replacement;
  - byte-enable writes;
  - explicit memory handshake (m_ren/mready) so memory may take any number of cycles.
- Instruction and data caches are each one instance; stall keeps the two in lockstep.

Parameters:
- TAG_WIDTH, 24, tag bits t; TAG_WIDTH+SET_WIDTH+OFFSET_WIDTH must equal 32.
- SET_WIDTH, 4, set index bits s; 2**s sets.
- OFFSET_WIDTH, 4, block offset bits b; b>=2; WORDS = 2**(b-2) words per line.
- LINES, 2, ways per set; power of two, >=1.

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  synchronous, active-high.
- stall  in  1  freezes CPU-side commits (see Behaviour).
- input_ready  in  1  CPU request valid.
- addr  in  32  byte address; bits [1:0] ignored.
- write_data  in  32  store data.
- w_en  in  1  1=store, 0=load.
- be  in  4  byte enables for stores; be[i] covers bits [8i+7:8i].
- hit  out  1  request satisfied this cycle.
- read_data  out  32  load data, valid when hit=1, else 0.
- maddr  out  32  word-aligned memory address.
- mwrite_data  out  32  memory write data.
- m_wen  out  1  memory write request.
- m_ren  out  1  memory read request.
- mread_data  in  32  memory read data, valid when mready=1 with m_ren=1.
- mready  in  1  memory accepts/completes current word this cycle.

Behaviour:
- Reset, synchronous: all valid and dirty bits cleared (no write-back); LRU age of way i = i; FSM to IDLE. After reset: hit=0, read_data=0, m_wen=0, m_ren=0, maddr=0, mwrite_data=0.
- Address split: tag=addr[31:32-t], set=addr[b+s-1:b], word=addr[b-1:2].
- FSM states: IDLE, WRITEBACK, REFILL.
- IDLE hit:
  - hit = input_ready && some way is valid with matching tag. Combinational, zero latency.
  - read_data = that way's word.
  - If stall=0 at the edge: a store writes only the bytes selected by be and sets dirty; LRU is updated for both loads and stores.
  - If stall=1: hit/read_data are still driven but no array or LRU change.
- IDLE miss (input_ready && !hit && !stall):
  - Latch set, tag and victim way. Victim = lowest-index invalid way, else the way with maximum age.
  - If the victim is valid and dirty, go to WRITEBACK with word counter k=0; else go to REFILL with k=0.
  - A miss with stall=1 does not start.
- WRITEBACK:
  - m_wen=1; maddr={victim_tag, set, k, 2'b00}; mwrite_data = victim word k. These are held stable until mready.
  - On mready: k++. On mready with k==WORDS-1: k=0, go to REFILL.
- REFILL:
  - m_ren=1; maddr={req_tag, set, k, 2'b00}.
  - On mready: store mread_data into word k of the victim way, k++.
  - On the last word: tag=req_tag, valid=1, dirty=0, go to IDLE.
  - The request then hits on the following cycle; the store merge happens then.
- m_wen and m_ren are never both 1; both are 0 in IDLE. stall does not pause WRITEBACK/REFILL.
- hit is 0 in WRITEBACK/REFILL. The CPU holds addr/w_en/write_data/be stable until it sees hit=1.
- LRU:
  - Per-set age counters, clog2(LINES) bits per way, always a permutation of 0..LINES-1.
  - On access to way w: every way with age<age[w] increments, and age[w]=0.
  - A refill counts as an access to the victim way.
  - LINES=1: age logic removed; victim is always way 0.
- Reset asserted mid-WRITEBACK/REFILL: the transfer is abandoned and the partially written line is discarded (valid=0). m_wen/m_ren drop in the cycle after the reset edge.
- input_ready=0: hit=0, no state change, FSM stays IDLE.

Test Plan:
- Cold load 0x0000_0100 with mready tied 1 → REFILL only (no m_wen); maddr 0x100, 0x104, 0x108, 0x10C in 4 consecutive cycles; hit=1 on the 5th cycle with read_data = mem[0x100].
- Store 0xDEADBEEF be=4'b0011 to 0x104 after it is cached → same-cycle hit; subsequent load 0x104 returns {old[31:16], 16'hBEEF}; no memory traffic.
- Dirty eviction, LINES=2: load 0x0100, store 0x1100, load 0x2100 (all set 0), then access 0x0100 → 0x1100 line is LRU and dirty; 4 m_wen beats to 0x1100–0x110C carrying the stored data, then 4 m_ren beats.
- mready toggling 1-0-1-0 during REFILL → maddr/m_ren held across low cycles; each word captured only on mready=1; final line content correct.
- Hit with stall=1 on a store → hit=1 but memory unchanged; repeating with stall=0 commits. Miss with stall=1 → FSM stays IDLE, m_ren=0.
- reset pulse during the 3rd WRITEBACK beat → next cycle m_wen=0, FSM IDLE; reload of the same address misses.
